// File: rtl/combo_tracker_multi_if.sv
// Bus bundle for combo_tracker_multi: per-channel hit/miss events in, combo/HUD values out.
interface combo_tracker_multi_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 7,
  parameter int MULT_W = 3
);
  logic [NUM_CH-1:0]        miss;
  logic [NUM_CH-1:0]        non_full_clear_hit;
  logic [NUM_CH-1:0]        full_clear_hit;
  logic                     clear_all;
  logic [NUM_CH*CNT_W-1:0]  combo_count;
  logic [NUM_CH*CNT_W-1:0]  best_combo;
  logic [NUM_CH*MULT_W-1:0] multiplier;
  logic [NUM_CH-1:0]        combo_broken;

  modport master (
    output miss, non_full_clear_hit, full_clear_hit, clear_all,
    input  combo_count, best_combo, multiplier, combo_broken
  );

  modport slave (
    input  miss, non_full_clear_hit, full_clear_hit, clear_all,
    output combo_count, best_combo, multiplier, combo_broken
  );
endinterface

// File: rtl/combo_tracker_multi.sv
// Multi-channel Whac-A-Mole combo tracker: edge-detected hits/misses, saturating combo,
// inactivity timeout, best-combo capture and tiered score multiplier.
module combo_tracker_multi #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 7,
  parameter int FULL_INC  = 2,
  parameter int TIMEOUT   = 50000000,
  parameter int TO_W      = 26,
  parameter int TIER_STEP = 10,
  parameter int MULT_MAX  = 4,
  parameter int MULT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  combo_tracker_multi_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   FULL_STEP = (CNT_W+1)'(FULL_INC);
  localparam logic [CNT_W:0]   ONE_STEP  = (CNT_W+1)'(1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

  logic [NUM_CH-1:0] r_prevMiss;
  logic [NUM_CH-1:0] r_prevNf;
  logic [NUM_CH-1:0] r_prevFull;
  logic              r_armed;
  logic [CNT_W-1:0]  r_combo [NUM_CH];
  logic [CNT_W-1:0]  r_best  [NUM_CH];
  logic [TO_W-1:0]   r_timer [NUM_CH];
  logic [NUM_CH-1:0] r_broken;

  logic [NUM_CH-1:0] w_missEv;
  logic [NUM_CH-1:0] w_nfEv;
  logic [NUM_CH-1:0] w_fullEv;
  logic [CNT_W:0]    w_sum       [NUM_CH];
  logic [CNT_W-1:0]  w_comboNext [NUM_CH];
  logic [CNT_W-1:0]  w_bestNext  [NUM_CH];
  logic [TO_W-1:0]   w_timerNext [NUM_CH];
  logic [NUM_CH-1:0] w_brokenNext;
  logic [MULT_W-1:0] w_mult      [NUM_CH];

  // r_armed masks the first edge after reset release, so an input already held
  // high through reset must drop and rise again before it counts.
  always_comb begin
    w_missEv     = bus.miss & ~r_prevMiss & {NUM_CH{r_armed}};
    w_nfEv       = bus.non_full_clear_hit & ~r_prevNf & {NUM_CH{r_armed}};
    w_fullEv     = bus.full_clear_hit & ~r_prevFull & {NUM_CH{r_armed}};
    w_brokenNext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum[i]       = {1'b0, r_combo[i]} + (w_fullEv[i] ? FULL_STEP : ONE_STEP);
      w_comboNext[i] = r_combo[i];
      w_timerNext[i] = r_timer[i];
      if (bus.clear_all) begin
        w_comboNext[i] = '0;
        w_timerNext[i] = '0;
      end else if (w_missEv[i]) begin
        w_comboNext[i]  = '0;
        w_timerNext[i]  = '0;
        w_brokenNext[i] = (r_combo[i] != '0);
      end else if (w_fullEv[i] || w_nfEv[i]) begin
        w_comboNext[i] = (w_sum[i] > {1'b0, CNT_MAX}) ? CNT_MAX : w_sum[i][CNT_W-1:0];
        w_timerNext[i] = TO_LOAD;
      end else if ((TIMEOUT != 0) && (r_combo[i] != '0) && (r_timer[i] != '0)) begin
        w_timerNext[i] = r_timer[i] - TO_ONE;
        if (r_timer[i] == TO_ONE) begin
          w_comboNext[i]  = '0;
          w_brokenNext[i] = 1'b1;
        end
      end
      w_bestNext[i] = (w_comboNext[i] > r_best[i]) ? w_comboNext[i] : r_best[i];
    end
  end

  // Tier thresholds are elaboration-time constants, so this is a compare chain, not a divider.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_mult[i] = MULT_W'(1);
      for (int k = 1; k < MULT_MAX; k++) begin
        if (int'(r_combo[i]) >= k * TIER_STEP) begin
          w_mult[i] = MULT_W'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prevMiss <= '0;
      r_prevNf   <= '0;
      r_prevFull <= '0;
      r_armed    <= 1'b0;
      r_broken   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_combo[i] <= '0;
        r_best[i]  <= '0;
        r_timer[i] <= '0;
      end
    end else begin
      r_prevMiss <= bus.miss;
      r_prevNf   <= bus.non_full_clear_hit;
      r_prevFull <= bus.full_clear_hit;
      r_armed    <= 1'b1;
      r_broken   <= w_brokenNext;
      for (int i = 0; i < NUM_CH; i++) begin
        r_combo[i] <= w_comboNext[i];
        r_best[i]  <= w_bestNext[i];
        r_timer[i] <= w_timerNext[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.combo_count[g*CNT_W +: CNT_W] = r_combo[g];
    assign bus.best_combo[g*CNT_W +: CNT_W]  = r_best[g];
    assign bus.multiplier[g*MULT_W +: MULT_W] = w_mult[g];
  end

  assign bus.combo_broken = r_broken;

endmodule

// File: doc/combo_tracker_multi.md
Name: combo_tracker_multi

Overview:
- Parametrised, multi-channel successor to the single-player combo counter in the Whac-A-Mole scoring path.
- Tracks one combo per channel (player or mole bank) from hit/miss pulses.
- Adds weighted hits, saturation, inactivity timeout, best-combo capture and a tiered score multiplier.
- Outputs feed the score accumulator and the 7-segment/HUD display logic.

Parameters:
- NUM_CH, 2: number of independent combo channels.
- CNT_W, 7: combo counter width; saturates at 2^CNT_W-1.
- FULL_INC, 2: increment applied for a full-clear hit.
- TIMEOUT, 50000000: idle cycles before a nonzero combo is dropped (1 s at 50 MHz). 0 disables the timeout.
- TO_W, 26: timeout timer width. Must hold TIMEOUT.
- TIER_STEP, 10: combo points per multiplier tier.
- MULT_MAX, 4: maximum multiplier value.
- MULT_W, 3: multiplier output width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- miss  in  NUM_CH  per-channel miss level/pulse.
- non_full_clear_hit  in  NUM_CH  per-channel ordinary hit.
- full_clear_hit  in  NUM_CH  per-channel full-clear hit.
- clear_all  in  1  synchronous clear of combos and timers. best_combo is kept.
- combo_count  out  NUM_CH*CNT_W  current combo; channel i occupies bits [i*CNT_W +: CNT_W].
- best_combo  out  NUM_CH*CNT_W  highest combo reached since reset.
- multiplier  out  NUM_CH*MULT_W  score multiplier per channel.
- combo_broken  out  NUM_CH  1-cycle pulse when a nonzero combo is lost.

Behaviour:
- All inputs are synchronous to clk.
- Edge detection:
  - Each event input has a previous-value register.
  - An event fires only on the first posedge where the input is 1 and its previous value is 0.
  - A level held for N cycles counts once.
  - Previous-value registers reset to 0.
- Reset values: combo_count = 0, best_combo = 0, multiplier = 1, combo_broken = 0, timers = 0, for all channels.
- Per-channel priority when events fire on the same edge: miss > full_clear_hit > non_full_clear_hit.
  - miss event: combo <= 0. If the old combo was nonzero, combo_broken pulses on the next cycle.
  - full event (no miss): combo <= min(combo + FULL_INC, 2^CNT_W-1).
  - non-full event only: combo <= min(combo + 1, 2^CNT_W-1).
  - Simultaneous full and non-full events: a single +FULL_INC.
- Latency: combo_count, best_combo and multiplier are valid in the cycle after the detecting posedge. No other latency.
- Timeout timer (only when TIMEOUT > 0):
  - Any hit event loads the timer with TIMEOUT.
  - While combo is nonzero and the timer is nonzero, it decrements by 1 per cycle.
  - When the timer goes 1->0 with combo nonzero: combo <= 0 and combo_broken pulses.
  - A hit on the expiry cycle wins: the combo increments and the timer reloads.
  - A miss clears the timer to 0.
- best_combo <= max(best_combo, next combo), updated on the same edge as the combo.
- multiplier = 1 + min(combo_count / TIER_STEP, MULT_MAX - 1).
  - Decoded from the registered combo, so no extra latency.
  - Resolved with constant thresholds; no runtime divider.
- clear_all:
  - Sets all combos and timers to 0 and suppresses event processing that cycle.
  - Does not pulse combo_broken.
  - Previous-value registers still sample, so inputs held across clear_all do not re-fire.
- Reset mid-operation: asynchronous clear regardless of the clock. No combo_broken pulse on reset.
- Channels are fully independent. No cross-channel interaction except clear_all and rst.

Test Plan:
- Single non-full pulse on ch0, 1 cycle wide, 4 times -> combo_count[ch0] = 4, multiplier = 1, best_combo = 4; ch1 stays 0.
- full_clear_hit ch0 held 2 cycles, from combo 4 -> combo = 6, not 8 (edge-detected); next full hit -> 8.
- miss and full_clear_hit on the same cycle, from combo 8 -> combo = 0, combo_broken pulses 1 cycle, best_combo = 8.
- Climb ch1 to 126 then full hit -> combo saturates at 127, multiplier = 4; 10 more hits -> stays 127.
- TIMEOUT overridden to 20: reach combo 3, then idle -> combo drops to 0 exactly 20 cycles after the last hit with a combo_broken pulse; a hit on cycle 20 instead yields combo 4 with no pulse.
- Assert rst low mid-stream with a non-full hit held high -> all outputs reset immediately. After release, the held input does not count until it toggles; clear_all clears combos but best_combo is kept.
